// File: rtl/sram_axi_bridge_mo.sv
// SRAM-like inst/data ports to one AXI3 master: multiple outstanding reads per port (by ARID), one write at a time.
// Latency: addr_ok combinational, AR/AW/W registered next cycle, data_ok combinational on R/B; backpressure via addr_ok.
module sram_axi_bridge_mo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int RD_OUT = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // inst port
  input  logic                  inst_sram_req,
  input  logic                  inst_sram_wr,
  input  logic [1:0]            inst_sram_size,
  input  logic [ADDR_W-1:0]     inst_sram_addr,
  input  logic [DATA_W/8-1:0]   inst_sram_wstrb,
  input  logic [DATA_W-1:0]     inst_sram_wdata,
  output logic                  inst_sram_addr_ok,
  output logic                  inst_sram_data_ok,
  output logic [DATA_W-1:0]     inst_sram_rdata,
  // data port
  input  logic                  data_sram_req,
  input  logic                  data_sram_wr,
  input  logic [1:0]            data_sram_size,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W/8-1:0]   data_sram_wstrb,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic                  data_sram_addr_ok,
  output logic                  data_sram_data_ok,
  output logic [DATA_W-1:0]     data_sram_rdata,
  // AR
  output logic [ID_W-1:0]       arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [3:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  // R
  input  logic [ID_W-1:0]       rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AW
  output logic [ID_W-1:0]       awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [3:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  // W
  output logic [ID_W-1:0]       wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // B
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int CNT_W = $clog2(RD_OUT + 1);
  localparam logic [ID_W-1:0]  INST_ID = '0;
  localparam logic [ID_W-1:0]  DATA_ID = ID_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

  wstate_t          wstate, wstate_nxt;
  logic [CNT_W-1:0] icnt, dcnt;
  logic             ar_free, i_dec, d_dec, i_cnt_ok, d_cnt_ok;
  logic             inst_rd_acc, data_rd_acc, wr_acc;

  wire unused_ok = &{1'b0, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = DATA_ID;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;

  // Beats for an id with nothing outstanding (e.g. after reset) are consumed silently.
  assign i_dec = rvalid && rready && (rid == INST_ID) && (icnt != '0);
  assign d_dec = rvalid && rready && (rid == DATA_ID) && (dcnt != '0);

  // A returning beat frees its slot in the same cycle.
  assign i_cnt_ok = (icnt != CNT_MAX) || i_dec;
  assign d_cnt_ok = (dcnt != CNT_MAX) || d_dec;

  assign ar_free     = !arvalid || arready;
  assign data_rd_acc = ar_free && data_sram_req && !data_sram_wr && d_cnt_ok && (wstate == W_IDLE);
  assign inst_rd_acc = ar_free && inst_sram_req && !inst_sram_wr && i_cnt_ok && !data_rd_acc;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || wr_acc;

  assign inst_sram_data_ok = i_dec;
  assign data_sram_data_ok = d_dec || ((wstate == W_RESP) && bvalid);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;
  assign bready            = (wstate == W_RESP);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rready  <= 1'b0;
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arsize  <= '0;
    end else begin
      rready <= 1'b1;
      if (data_rd_acc) begin
        arvalid <= 1'b1;
        arid    <= DATA_ID;
        araddr  <= data_sram_addr;
        arsize  <= {1'b0, data_sram_size};
      end else if (inst_rd_acc) begin
        arvalid <= 1'b1;
        arid    <= INST_ID;
        araddr  <= inst_sram_addr;
        arsize  <= {1'b0, inst_sram_size};
      end else if (arready) begin
        arvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (inst_rd_acc && !i_dec)      icnt <= icnt + CNT_ONE;
      else if (!inst_rd_acc && i_dec) icnt <= icnt - CNT_ONE;
      if (data_rd_acc && !d_dec)      dcnt <= dcnt + CNT_ONE;
      else if (!data_rd_acc && d_dec) dcnt <= dcnt - CNT_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) wstate <= W_IDLE;
    else          wstate <= wstate_nxt;
  end

  // Writes wait for all data reads to drain so data-port responses stay in order.
  always_comb begin
    wstate_nxt = wstate;
    wr_acc     = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (data_sram_req && data_sram_wr && (dcnt == '0)) begin
          wr_acc     = 1'b1;
          wstate_nxt = W_SEND;
        end
      end
      W_SEND: begin
        if ((!awvalid || awready) && (!wvalid || wready)) wstate_nxt = W_RESP;
      end
      W_RESP: begin
        if (bvalid) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else if (wr_acc) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      awaddr  <= data_sram_addr;
      awsize  <= {1'b0, data_sram_size};
      wdata   <= data_sram_wdata;
      wstrb   <= data_sram_wstrb;
    end else begin
      if (awready) awvalid <= 1'b0;
      if (wready)  wvalid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge_mo.sv
// Directed bench for sram_axi_bridge_mo; expected responses queued at request acceptance, compared on data_ok.
module tb_sram_axi_bridge_mo;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int RD_OUT = 2;

  logic aclk = 1'b0;
  logic aresetn;
  logic inst_sram_req, inst_sram_wr;
  logic [1:0] inst_sram_size;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W/8-1:0] inst_sram_wstrb;
  logic [DATA_W-1:0] inst_sram_wdata;
  logic inst_sram_addr_ok, inst_sram_data_ok;
  logic [DATA_W-1:0] inst_sram_rdata;
  logic data_sram_req, data_sram_wr;
  logic [1:0] data_sram_size;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W/8-1:0] data_sram_wstrb;
  logic [DATA_W-1:0] data_sram_wdata;
  logic data_sram_addr_ok, data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic [ID_W-1:0] arid, awid, wid, rid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [3:0] arlen, awlen, arcache, awcache;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready;

  sram_axi_bridge_mo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RD_OUT(RD_OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  // Entries: MSB set marks a write completion, otherwise the low bits are the read data.
  logic [DATA_W:0] inst_q[$];
  logic [DATA_W:0] data_q[$];
  logic [DATA_W:0] ie, de;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd_pat(input logic [ADDR_W-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  always @(negedge aclk) begin
    if (inst_sram_data_ok) begin
      if (inst_q.size() == 0) chk_eq("inst_unexp_ok", 1, 0);
      else begin
        ie = inst_q.pop_front();
        chk_eq("inst_rdata", inst_sram_rdata, ie[DATA_W-1:0]);
      end
    end
    if (data_sram_data_ok) begin
      if (data_q.size() == 0) chk_eq("data_unexp_ok", 1, 0);
      else begin
        de = data_q.pop_front();
        if (de[DATA_W]) chk_eq("data_wr_done_b", bvalid, 1);
        else            chk_eq("data_rdata", data_sram_rdata, de[DATA_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    logic got_b;
    aresetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = '0;
    inst_sram_wstrb = '0; inst_sram_wdata = '0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = '0;
    data_sram_wstrb = '0; data_sram_wdata = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;

    // reset state
    repeat (3) tick();
    smp();
    chk_eq("rst_arvalid", arvalid, 0);
    chk_eq("rst_awvalid", awvalid, 0);
    chk_eq("rst_wvalid", wvalid, 0);
    chk_eq("rst_rready", rready, 0);
    chk_eq("rst_bready", bready, 0);
    chk_eq("rst_araddr", araddr, 0);
    chk_eq("rst_icnt", dut.icnt, 0);
    aresetn = 1'b1;
    tick(); tick();
    smp();
    chk_eq("rready_up", rready, 1);
    chk_eq("const_wlast", wlast, 1);
    chk_eq("const_awid", awid, 1);
    chk_eq("const_arburst", arburst, 1);

    // inst write never accepted
    tick(); inst_sram_req = 1; inst_sram_wr = 1; inst_sram_addr = 32'h1FC0_0000;
    smp(); chk_eq("inst_wr_rej", inst_sram_addr_ok, 0);

    // single inst read
    tick(); inst_sram_wr = 0; arready = 1;
    smp(); chk_eq("s1_addr_ok", inst_sram_addr_ok, 1);
    if (inst_sram_addr_ok) inst_q.push_back({1'b0, 32'h2402_0001});
    tick(); inst_sram_req = 0;
    smp();
    chk_eq("s1_arvalid", arvalid, 1);
    chk_eq("s1_arid", arid, 0);
    chk_eq("s1_araddr", araddr, 32'h1FC0_0000);
    chk_eq("s1_arsize", arsize, 2);
    tick(); rvalid = 1; rid = 0; rdata = 32'h2402_0001;
    smp(); chk_eq("s1_data_ok", inst_sram_data_ok, 1); chk_eq("s1_ar_done", arvalid, 0);
    tick(); rid = 4'd2; rdata = 32'h0BAD_0BAD;
    smp(); chk_eq("s1_one_pulse", inst_sram_data_ok, 0);
    chk_eq("bad_id_data", data_sram_data_ok, 0);
    tick(); rvalid = 0;
    smp(); chk_eq("s1_icnt0", dut.icnt, 0);

    // simultaneous requests, out-of-order return
    tick(); inst_sram_req = 1; inst_sram_addr = 32'h1FC0_0100;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1000;
    smp(); chk_eq("s2_data_first", data_sram_addr_ok, 1); chk_eq("s2_inst_wait", inst_sram_addr_ok, 0);
    if (data_sram_addr_ok) data_q.push_back({1'b0, rd_pat(32'h0000_1000)});
    tick(); data_sram_req = 0;
    smp();
    chk_eq("s2_arid_d", arid, 1); chk_eq("s2_araddr_d", araddr, 32'h0000_1000);
    chk_eq("s2_inst_ok", inst_sram_addr_ok, 1);
    if (inst_sram_addr_ok) inst_q.push_back({1'b0, rd_pat(32'h1FC0_0100)});
    tick(); inst_sram_req = 0;
    smp(); chk_eq("s2_arid_i", arid, 0); chk_eq("s2_araddr_i", araddr, 32'h1FC0_0100);
    tick(); rvalid = 1; rid = 0; rdata = rd_pat(32'h1FC0_0100);
    smp(); chk_eq("s2_no_cross_d", data_sram_data_ok, 0);
    tick(); rid = 1; rdata = rd_pat(32'h0000_1000);
    smp(); chk_eq("s2_no_cross_i", inst_sram_data_ok, 0);
    tick(); rvalid = 0;

    // counter full on inst port
    inst_sram_req = 1; inst_sram_addr = 32'h0000_0040;
    smp(); chk_eq("s3_acc0", inst_sram_addr_ok, 1);
    if (inst_sram_addr_ok) inst_q.push_back({1'b0, rd_pat(32'h0000_0040)});
    tick(); inst_sram_addr = 32'h0000_0044;
    smp(); chk_eq("s3_acc1", inst_sram_addr_ok, 1);
    if (inst_sram_addr_ok) inst_q.push_back({1'b0, rd_pat(32'h0000_0044)});
    tick(); inst_sram_addr = 32'h0000_0048;
    smp(); chk_eq("s3_full_block", inst_sram_addr_ok, 0);
    tick(); rvalid = 1; rid = 0; rdata = rd_pat(32'h0000_0040);
    smp(); chk_eq("s3_resume_same", inst_sram_addr_ok, 1);
    if (inst_sram_addr_ok) inst_q.push_back({1'b0, rd_pat(32'h0000_0048)});
    tick(); inst_sram_req = 0; rdata = rd_pat(32'h0000_0044);
    smp();
    tick(); rdata = rd_pat(32'h0000_0048);
    smp();
    tick(); rvalid = 0;
    smp(); chk_eq("s3_icnt0", dut.icnt, 0);

    // write with W before AW, then a data read held off by the write
    tick(); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h8000_0010;
    data_sram_wdata = 32'hDEAD_BEEF; data_sram_wstrb = 4'hF;
    smp(); chk_eq("s4_wr_addr_ok", data_sram_addr_ok, 1);
    if (data_sram_addr_ok) data_q.push_back({1'b1, 32'h0});
    tick(); data_sram_wr = 0; data_sram_addr = 32'h0000_2000; wready = 1;
    smp();
    chk_eq("s4_awvalid", awvalid, 1); chk_eq("s4_wvalid", wvalid, 1);
    chk_eq("s4_awaddr", awaddr, 32'h8000_0010); chk_eq("s4_wdata", wdata, 32'hDEAD_BEEF);
    chk_eq("s4_wstrb", wstrb, 4'hF); chk_eq("s4_awsize", awsize, 2);
    chk_eq("s4_rd_blk_send", data_sram_addr_ok, 0);
    tick(); wready = 0; awready = 1;
    smp();
    chk_eq("s4_w_done", wvalid, 0); chk_eq("s4_aw_wait", awvalid, 1);
    chk_eq("s4_no_resp_early", bready, 0); chk_eq("s4_rd_blk_send2", data_sram_addr_ok, 0);
    tick(); awready = 0;
    smp();
    chk_eq("s4_aw_done", awvalid, 0); chk_eq("s4_bready", bready, 1);
    chk_eq("s4_rd_blk_resp", data_sram_addr_ok, 0);
    tick(); bvalid = 1;
    smp(); chk_eq("s4_wr_data_ok", data_sram_data_ok, 1); chk_eq("s4_rd_blk_b", data_sram_addr_ok, 0);
    tick(); bvalid = 0;
    smp(); chk_eq("s4_idle_bready", bready, 0); chk_eq("s4_rd_after_wr", data_sram_addr_ok, 1);
    if (data_sram_addr_ok) data_q.push_back({1'b0, rd_pat(32'h0000_2000)});
    tick(); data_sram_req = 0;
    smp(); chk_eq("s4_arid", arid, 1); chk_eq("s4_araddr", araddr, 32'h0000_2000);
    tick(); rvalid = 1; rid = 1; rdata = rd_pat(32'h0000_2000);
    smp();
    tick(); rvalid = 0;

    // write held off by an outstanding data read
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_3000;
    smp(); chk_eq("s5_rd_ok", data_sram_addr_ok, 1);
    if (data_sram_addr_ok) data_q.push_back({1'b0, rd_pat(32'h0000_3000)});
    tick(); data_sram_wr = 1; data_sram_addr = 32'h8000_0020;
    data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'h3;
    smp(); chk_eq("s5_wr_blk", data_sram_addr_ok, 0);
    tick();
    smp(); chk_eq("s5_wr_blk2", data_sram_addr_ok, 0);
    tick(); rvalid = 1; rid = 1; rdata = rd_pat(32'h0000_3000);
    smp();
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); rvalid = 0;
      smp();
      if (data_sram_addr_ok) begin acc = 1'b1; break; end
    end
    chk_eq("s5_wr_accept", acc, 1);
    if (acc) data_q.push_back({1'b1, 32'h0});
    tick(); data_sram_req = 0; awready = 1; wready = 1;
    smp(); chk_eq("s5_wdata", wdata, 32'h1234_5678); chk_eq("s5_wstrb", wstrb, 4'h3);
    got_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      smp();
      if (bready) begin got_b = 1'b1; break; end
    end
    chk_eq("s5_bready", got_b, 1);
    tick(); bvalid = 1; awready = 0; wready = 0;
    smp();
    tick(); bvalid = 0;

    // reset with AR pending and two data reads outstanding
    arready = 1; data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_4000;
    smp(); chk_eq("s6_acc0", data_sram_addr_ok, 1);
    if (data_sram_addr_ok) data_q.push_back({1'b0, rd_pat(32'h0000_4000)});
    tick(); data_sram_addr = 32'h0000_4004;
    smp(); chk_eq("s6_acc1", data_sram_addr_ok, 1);
    if (data_sram_addr_ok) data_q.push_back({1'b0, rd_pat(32'h0000_4004)});
    tick(); data_sram_req = 0; arready = 0;
    smp(); chk_eq("s6_arvalid", arvalid, 1); chk_eq("s6_dcnt2", dut.dcnt, 2);
    tick(); aresetn = 0;
    smp();
    tick();
    smp();
    inst_q.delete(); data_q.delete();
    chk_eq("s6_arvalid_clr", arvalid, 0); chk_eq("s6_dcnt_clr", dut.dcnt, 0);
    chk_eq("s6_rready_clr", rready, 0); chk_eq("s6_data_ok_clr", data_sram_data_ok, 0);
    tick(); aresetn = 1;
    tick(); rvalid = 1; rid = 1; rdata = 32'hCAFE_F00D;
    smp(); chk_eq("s6_rready", rready, 1); chk_eq("s6_drop_stale", data_sram_data_ok, 0);
    tick(); rvalid = 0;
    smp();

    chk_eq("inst_q_empty", inst_q.size(), 0);
    chk_eq("data_q_empty", data_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
